// File: rtl/keccak_pkg.sv
// Shared constants and FSM state encoding for the Keccak-f[1600] sponge controller.
// Latency: none (declarations only).
// Backpressure: not applicable.
package keccak_pkg;

   localparam int NUM_ROUNDS = 24;    // rounds per Keccak-f[1600] permutation
   localparam int ROUND_W    = 5;     // width of a round index (0..23)
   localparam int RATE_W     = 1088;  // rate block width absorbed per handshake
   localparam int STATE_W    = 1600;  // full sponge state width

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT_BLK = 2'd1,
      PERMUTE  = 2'd2,
      DONE     = 2'd3
   } ctrl_state_t;

endpackage

// File: rtl/keccak_sponge_ctrl_if.sv
// Bundle of the requester handshake, datapath enables and status of the sponge controller.
// Latency: none (wiring only).
// Backpressure: blk_ready is driven by the controller; the requester holds blk_valid until it sees it.
//
// Modports:
//   slave  - the controller: samples start/blk_valid/blk_last/digest_ack, drives everything else.
//   master - the requester/consumer side: the mirror image.
interface keccak_sponge_ctrl_if #(
   parameter int CNT_W = 16
);
   import keccak_pkg::*;

   logic               start;
   logic               blk_valid;
   logic               blk_last;
   logic               blk_ready;
   logic               dp_state_clr;
   logic               dp_absorb_en;
   logic               dp_step_en;
   logic [ROUND_W-1:0] dp_round_idx;
   logic               digest_valid;
   logic               digest_ack;
   logic               busy;
   logic [CNT_W-1:0]   blk_count;
   logic [31:0]        cycle_count;

   modport slave (
      input  start, blk_valid, blk_last, digest_ack,
      output blk_ready, dp_state_clr, dp_absorb_en, dp_step_en, dp_round_idx,
             digest_valid, busy, blk_count, cycle_count
   );

   modport master (
      output start, blk_valid, blk_last, digest_ack,
      input  blk_ready, dp_state_clr, dp_absorb_en, dp_step_en, dp_round_idx,
             digest_valid, busy, blk_count, cycle_count
   );

endinterface

// File: rtl/keccak_sponge_ctrl.sv
// Sequencing controller for the unrolled Keccak-f[1600] datapath (absorb stage, round chain, state reg).
// Latency: 24/UNROLL step cycles per block including the absorb cycle; digest_valid the cycle after the last step.
// Backpressure: blk_ready only in WAIT_BLK; blk_valid elsewhere is ignored; digest_valid holds until digest_ack.
//
// Ports: clk, reset (synchronous, active-high), bus (keccak_sponge_ctrl_if.slave).
// Optional build macro KECCAK_CTRL_PERF_EN enables the cycle_count performance counter;
// without it cycle_count is tied to zero.
// UNROLL must divide 24 so the round counter lands exactly on 24-UNROLL.
module keccak_sponge_ctrl
   import keccak_pkg::*;
#(
   parameter int UNROLL = 2,
   parameter int CNT_W  = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   keccak_sponge_ctrl_if.slave  bus
);

   localparam logic [ROUND_W-1:0] STEP     = ROUND_W'(UNROLL);
   localparam logic [ROUND_W-1:0] LAST_IDX = ROUND_W'(NUM_ROUNDS - UNROLL);
   // With full unroll the absorb cycle is also the whole permutation.
   localparam bit                 ONE_SHOT = (UNROLL == NUM_ROUNDS);

   ctrl_state_t        state;
   logic [ROUND_W-1:0] round_q;
   logic               last_q;
   logic [CNT_W-1:0]   blk_count_q;

   logic handshake;
   logic start_ok;

   // Mealy terms are masked by reset so a reset cycle never leaks an enable.
   assign handshake = (state == WAIT_BLK) & bus.blk_valid & ~reset;
   assign start_ok  = (state == IDLE) & bus.start & ~reset;

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         round_q     <= '0;
         last_q      <= 1'b0;
         blk_count_q <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  state       <= WAIT_BLK;
                  blk_count_q <= '0;
               end
            end
            WAIT_BLK: begin
               if (bus.blk_valid) begin
                  last_q <= bus.blk_last;
                  if (blk_count_q != '1)
                     blk_count_q <= blk_count_q + CNT_W'(1);
                  if (ONE_SHOT) begin
                     round_q <= '0;
                     state   <= bus.blk_last ? DONE : WAIT_BLK;
                  end else begin
                     round_q <= STEP;
                     state   <= PERMUTE;
                  end
               end
            end
            PERMUTE: begin
               if (round_q == LAST_IDX) begin
                  round_q <= '0;
                  state   <= last_q ? DONE : WAIT_BLK;
               end else begin
                  round_q <= round_q + STEP;
               end
            end
            DONE: begin
               // A start arriving with the ack is dropped: only IDLE honours start.
               if (bus.digest_ack)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.blk_ready    = (state == WAIT_BLK);
   assign bus.digest_valid = (state == DONE);
   assign bus.busy         = (state != IDLE);
   assign bus.dp_state_clr = start_ok;
   assign bus.dp_absorb_en = handshake;
   assign bus.dp_step_en   = handshake | (state == PERMUTE);
   // round_q is zero in WAIT_BLK, so the absorb cycle always reports round 0.
   assign bus.dp_round_idx = (state == PERMUTE) ? round_q : '0;
   assign bus.blk_count    = blk_count_q;

`ifdef KECCAK_CTRL_PERF_EN
   logic [31:0] cycle_q;

   always_ff @(posedge clk) begin
      if (reset)
         cycle_q <= '0;
      else if (start_ok)
         cycle_q <= '0;
      else if (((state == WAIT_BLK) || (state == PERMUTE)) && (cycle_q != '1))
         cycle_q <= cycle_q + 32'd1;
   end

   assign bus.cycle_count = cycle_q;
`else
   assign bus.cycle_count = '0;
`endif

endmodule
